// File: rtl/mcp9808_temp_decoder_if.sv
// Handshake and result bundle for the MCP9808 ambient-temperature decoder.
// master drives raw samples; slave is the decoder producing BCD results.
interface mcp9808_temp_decoder_if;
   logic [15:0] raw_i;
   logic        raw_valid;
   logic        busy;
   logic        valid_o;
   logic        sign_o;
   logic [11:0] int_bcd;
   logic [15:0] frac_bcd;
   logic        crit_o;
   logic        upper_o;
   logic        lower_o;
   logic        overrun;

   modport master (
      output raw_i, raw_valid,
      input  busy, valid_o, sign_o, int_bcd, frac_bcd,
             crit_o, upper_o, lower_o, overrun
   );

   modport slave (
      input  raw_i, raw_valid,
      output busy, valid_o, sign_o, int_bcd, frac_bcd,
             crit_o, upper_o, lower_o, overrun
   );
endinterface

// File: rtl/mcp9808_temp_decoder.sv
// Decodes an MCP9808 ambient-temperature word into sign + BCD integer/fraction
// using one shared double-dabble shifter: 9 steps for degrees, 14 for the fraction.
module mcp9808_temp_decoder (
   input  logic                         clk,
   input  logic                         rst,
   mcp9808_temp_decoder_if.slave        bus
);
   typedef enum logic [1:0] {IDLE, CONV_INT, CONV_FRAC, DONE} state_t;

   state_t      state, state_nxt;
   logic        capture;
   logic        last_step;

   logic [15:0] bcd_w;
   logic [13:0] bin_w;
   logic [3:0]  cnt;
   logic [13:0] frac_prod;
   logic [11:0] int_acc;
   logic [3:0]  cap_flags;   // {crit, upper, lower, sign}

   logic [12:0] mag;
   logic [13:0] frac14;
   logic [13:0] prod_in;
   logic [15:0] bcd_adj;
   logic [29:0] stepped;

   logic        valid_r, sign_r, crit_r, upper_r, lower_r, overrun_r;
   logic [11:0] int_r;
   logic [15:0] frac_r;

   always_comb begin
      mag     = bus.raw_i[12] ? (13'h0 - bus.raw_i[12:0]) : bus.raw_i[12:0];
      frac14  = {10'b0, mag[3:0]};
      // x625 as 512+64+32+16+1
      prod_in = (frac14 << 9) + (frac14 << 6) + (frac14 << 5) + (frac14 << 4) + frac14;
   end

   always_comb begin
      bcd_adj = bcd_w;
      for (int unsigned d = 0; d < 4; d++) begin
         if (bcd_w[d*4 +: 4] >= 4'd5)
            bcd_adj[d*4 +: 4] = bcd_w[d*4 +: 4] + 4'd3;
      end
      stepped = {bcd_adj, bin_w} << 1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      capture   = 1'b0;
      last_step = (cnt == 4'd0);
      case (state)
         IDLE: begin
            if (bus.raw_valid) begin
               capture   = 1'b1;
               state_nxt = CONV_INT;
            end else begin
               state_nxt = IDLE;
            end
         end
         CONV_INT:  state_nxt = last_step ? CONV_FRAC : CONV_INT;
         CONV_FRAC: state_nxt = last_step ? DONE : CONV_FRAC;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcd_w     <= '0;
         bin_w     <= '0;
         cnt       <= '0;
         frac_prod <= '0;
         int_acc   <= '0;
         cap_flags <= '0;
         valid_r   <= 1'b0;
         sign_r    <= 1'b0;
         crit_r    <= 1'b0;
         upper_r   <= 1'b0;
         lower_r   <= 1'b0;
         overrun_r <= 1'b0;
         int_r     <= '0;
         frac_r    <= '0;
      end else begin
         valid_r <= 1'b0;
         if (bus.raw_valid && state != IDLE)
            overrun_r <= 1'b1;
         if (capture) begin
            // integer part is left-aligned so its MSB shifts out of bin_w[13] first
            bin_w     <= {mag[12:4], 5'b0};
            bcd_w     <= '0;
            cnt       <= 4'd8;
            frac_prod <= prod_in;
            cap_flags <= bus.raw_i[15:12];
            overrun_r <= 1'b0;
         end else if (state == CONV_INT) begin
            if (last_step) begin
               int_acc <= stepped[25:14];
               bcd_w   <= '0;
               bin_w   <= frac_prod;
               cnt     <= 4'd13;
            end else begin
               bcd_w <= stepped[29:14];
               bin_w <= stepped[13:0];
               cnt   <= cnt - 4'd1;
            end
         end else if (state == CONV_FRAC) begin
            if (last_step) begin
               int_r   <= int_acc;
               frac_r  <= stepped[29:14];
               sign_r  <= cap_flags[0];
               lower_r <= cap_flags[1];
               upper_r <= cap_flags[2];
               crit_r  <= cap_flags[3];
               valid_r <= 1'b1;
            end else begin
               bcd_w <= stepped[29:14];
               bin_w <= stepped[13:0];
               cnt   <= cnt - 4'd1;
            end
         end
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.valid_o  = valid_r;
   assign bus.sign_o   = sign_r;
   assign bus.int_bcd  = int_r;
   assign bus.frac_bcd = frac_r;
   assign bus.crit_o   = crit_r;
   assign bus.upper_o  = upper_r;
   assign bus.lower_o  = lower_r;
   assign bus.overrun  = overrun_r;
endmodule

// File: tb/tb_mcp9808_temp_decoder.sv
// Self-checking bench for mcp9808_temp_decoder: directed spec vectors, random
// samples against an arithmetic reference, overrun, reset abort and back-to-back.
module tb_mcp9808_temp_decoder;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mcp9808_temp_decoder_if bus ();

   mcp9808_temp_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {crit, upper, lower, sign, int_bcd[11:0], frac_bcd[15:0]}
   function automatic logic [31:0] model(input logic [15:0] r);
      int unsigned mag, ip, fp;
      logic [11:0] ib;
      logic [15:0] fb;
      mag = r[12] ? ((32'd8192 - 32'(r[12:0])) % 32'd8192) : 32'(r[12:0]);
      ip  = mag / 16;
      fp  = (mag % 16) * 625;
      ib  = {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10)};
      fb  = {4'(fp / 1000), 4'((fp / 100) % 10), 4'((fp / 10) % 10), 4'(fp % 10)};
      return {r[15:13], r[12], ib, fb};
   endfunction

   function automatic logic [31:0] observed();
      return {bus.crit_o, bus.upper_o, bus.lower_o, bus.sign_o, bus.int_bcd, bus.frac_bcd};
   endfunction

   task automatic send(input logic [15:0] r);
      @(negedge clk);
      bus.raw_i     = r;
      bus.raw_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.raw_valid = 1'b0;
      bus.raw_i     = 16'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.valid_o) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic count_valids(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.valid_o) n++;
      end
   endtask

   task automatic test_reset;
      rst           = 1'b0;
      bus.raw_valid = 1'b0;
      bus.raw_i     = '0;
      #2;
      checks++;
      if ({bus.busy, bus.valid_o, bus.overrun} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 000", {bus.busy, bus.valid_o, bus.overrun});
      end
      checks++;
      if (observed() !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 00000000", observed());
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_directed;
      logic [15:0] raws [5];
      logic [31:0] exps [5];
      int lat;
      raws = '{16'h0194, 16'h1FFF, 16'hFD80, 16'h0FFF, 16'h5000};
      exps = '{{4'b0000, 12'h025, 16'h2500},
               {4'b0001, 12'h000, 16'h0625},
               {4'b1111, 12'h040, 16'h0000},
               {4'b0000, 12'h255, 16'h9375},
               {4'b0101, 12'h256, 16'h0000}};
      for (int k = 0; k < 5; k++) begin
         send(raws[k]);
         checks++;
         if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL dir_busy_e0[%0d]: got %b want 1", k, bus.busy);
         end
         wait_valid(lat);
         checks++;
         if (lat != 23) begin
            failures++;
            $display("FAIL dir_latency[%0d]: got %0d want 23", k, lat);
         end
         checks++;
         if (observed() !== exps[k]) begin
            failures++;
            $display("FAIL dir_result[%0d] raw=%h: got %h want %h", k, raws[k], observed(), exps[k]);
         end
         checks++;
         if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL dir_busy_e23[%0d]: got %b want 1", k, bus.busy);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({bus.busy, bus.valid_o} !== 2'b00 || observed() !== exps[k]) begin
            failures++;
            $display("FAIL dir_e24[%0d]: got busy/valid %b out %h want 00 %h",
                     k, {bus.busy, bus.valid_o}, observed(), exps[k]);
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] r;
      logic [31:0] e;
      int lat;
      for (int k = 0; k < 30; k++) begin
         r = 16'($urandom);
         if (k == 0) r = 16'h1000;
         if (k == 1) r = 16'hE000;
         e = model(r);
         send(r);
         wait_valid(lat);
         checks++;
         if (lat != 23 || observed() !== e) begin
            failures++;
            $display("FAIL rand[%0d] raw=%h: got lat %0d out %h want lat 23 out %h",
                     k, r, lat, observed(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_overrun;
      int lat, n;
      send(16'h07D0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.raw_valid = 1'b1;
      bus.raw_i     = 16'h0194;
      @(posedge clk);
      #1;
      bus.raw_valid = 1'b0;
      checks++;
      if ({bus.overrun, bus.busy} !== 2'b11) begin
         failures++;
         $display("FAIL ovr_set: got overrun/busy %b want 11", {bus.overrun, bus.busy});
      end
      wait_valid(lat);
      checks++;
      if (lat != 18 || observed() !== {4'b0000, 12'h125, 16'h0000}) begin
         failures++;
         $display("FAIL ovr_result: got lat %0d out %h want lat 18 out 01250000", lat, observed());
      end
      checks++;
      if (bus.overrun !== 1'b1) begin
         failures++;
         $display("FAIL ovr_hold: got %b want 1", bus.overrun);
      end
      @(negedge clk);
      bus.raw_valid = 1'b1;
      bus.raw_i     = 16'h0FFF;
      @(posedge clk);
      #1;
      bus.raw_valid = 1'b0;
      checks++;
      if ({bus.busy, bus.overrun} !== 2'b01) begin
         failures++;
         $display("FAIL ovr_e24_drop: got busy/overrun %b want 01", {bus.busy, bus.overrun});
      end
      count_valids(40, n);
      checks++;
      if (n != 0) begin
         failures++;
         $display("FAIL ovr_no_extra_valid: got %0d pulses want 0", n);
      end
      send(16'h0194);
      checks++;
      if (bus.overrun !== 1'b0) begin
         failures++;
         $display("FAIL ovr_clear: got %b want 0", bus.overrun);
      end
      wait_valid(lat);
      checks++;
      if (lat != 23 || observed() !== {4'b0000, 12'h025, 16'h2500}) begin
         failures++;
         $display("FAIL ovr_after: got lat %0d out %h want lat 23 out 00252500", lat, observed());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort;
      int lat, n;
      send(16'hFD80);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.valid_o, bus.overrun} !== 3'b000 || observed() !== 32'h0) begin
         failures++;
         $display("FAIL abort_async: got ctrl %b out %h want 000 00000000",
                  {bus.busy, bus.valid_o, bus.overrun}, observed());
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      count_valids(30, n);
      checks++;
      if (n != 0 || observed() !== 32'h0) begin
         failures++;
         $display("FAIL abort_no_valid: got %0d pulses out %h want 0 00000000", n, observed());
      end
      send(16'h0FFF);
      wait_valid(lat);
      checks++;
      if (lat != 23 || observed() !== {4'b0000, 12'h255, 16'h9375}) begin
         failures++;
         $display("FAIL abort_recover: got lat %0d out %h want lat 23 out 02559375", lat, observed());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      logic [15:0] a, b;
      int lat;
      for (int k = 0; k < 4; k++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if (k == 0) begin
            a = 16'h0FFF;
            b = 16'h1FFF;
         end
         send(a);
         wait_valid(lat);
         checks++;
         if (lat != 23 || observed() !== model(a)) begin
            failures++;
            $display("FAIL b2b_first[%0d]: got lat %0d out %h want lat 23 out %h", k, lat, observed(), model(a));
         end
         @(posedge clk);
         #1;
         send(b);
         checks++;
         if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_e25[%0d]: got busy %b want 1", k, bus.busy);
         end
         wait_valid(lat);
         checks++;
         if (lat != 23 || observed() !== model(b)) begin
            failures++;
            $display("FAIL b2b_second[%0d]: got lat %0d out %h want lat 23 out %h", k, lat, observed(), model(b));
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset;
      test_directed;
      test_random;
      test_overrun;
      test_reset_abort;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mcp9808_temp_decoder.md
MCP9808_TEMP_DECODER -- requirements
Module: mcp9808_temp_decoder

Interface
REQ-001 Parameters: none; the block SHALL be parameter-free.
REQ-002 clk  input  1  single clock for all state; rising-edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 raw_i  input  16  raw MCP9808 ambient-temperature register word (bit15 crit, bit14 upper, bit13 lower, bit12 sign, bits11:0 magnitude in 1/16 degC).
REQ-005 raw_valid  input  1  single-cycle strobe qualifying raw_i.
REQ-006 busy  output  1  conversion in progress; raw_valid is not accepted while high.
REQ-007 valid_o  output  1  one-cycle pulse; result outputs are updated in this cycle.
REQ-008 sign_o  output  1  1 = negative temperature.
REQ-009 int_bcd  output  12  three BCD digits of integer degrees (0-256).
REQ-010 frac_bcd  output  16  four BCD digits of fractional degrees x10^-4 (0000-9375).
REQ-011 crit_o, upper_o, lower_o  output  1 each  alert flags copied from raw_i[15:13].
REQ-012 overrun  output  1  sticky; set when raw_valid arrives while busy.

Function
REQ-013 States SHALL be IDLE, CONV_INT, CONV_FRAC and DONE; undefined encodings SHALL go to IDLE.
REQ-014 In IDLE, raw_valid=1 at edge E0 SHALL capture raw_i, clear overrun, load the conversion counters, and move to CONV_INT.
REQ-015 The captured magnitude SHALL be mag[12:0] = raw[12] ? (13'h0 - raw[12:0]) : raw[12:0]; integer = mag[12:4] (9 bit), frac = mag[3:0].
REQ-016 The frac product SHALL be frac*625 (14 bit), formed as a shift-add (512+64+32+16+1) with no multiplier.
REQ-017 CONV_INT SHALL run a shift-and-add-3 (double-dabble) conversion for exactly 9 edges (E1-E9), adding 3 to any digit >=5 before each shift; at E9 go to CONV_FRAC.
REQ-018 CONV_FRAC SHALL run the same algorithm on the 14-bit product for exactly 14 edges (E10-E23); at E23 go to DONE.
REQ-019 At E23 int_bcd, frac_bcd, sign_o and the three flags SHALL update together; valid_o SHALL be 1 for the cycle E23-E24 only.
REQ-020 At E24 DONE SHALL return to IDLE; a raw_valid sampled at E24 is not accepted; the earliest next capture is E25.
REQ-021 busy SHALL be 1 from E0 through E24, i.e. whenever the state is not IDLE.
REQ-022 raw_valid while busy SHALL be dropped without affecting the running conversion and SHALL set overrun.
REQ-023 Result outputs SHALL hold their last value between valid_o pulses.
REQ-024 raw[12:0]=13'h1000 SHALL decode to -256.0000 (int_bcd 12'h256); no saturation is applied.
REQ-025 sign_o SHALL equal captured raw[12] verbatim, including for zero magnitude.

Reset
REQ-026 rst=0 SHALL immediately, without a clock edge, force IDLE, busy=0, valid_o=0, overrun=0, sign_o=0, int_bcd=0, frac_bcd=0 and all flags 0.
REQ-027 Reset mid-conversion SHALL abort it; no valid_o SHALL follow for the aborted sample.
REQ-028 After rst deasserts, the first edge with raw_valid=1 SHALL be accepted as E0.

Verification
REQ-029 raw 16'h0194 -> valid_o 23 edges after capture; sign_o 0, int_bcd 12'h025, frac_bcd 16'h2500, flags 000.
REQ-030 raw 16'h1FFF -> sign_o 1, int_bcd 12'h000, frac_bcd 16'h0625.
REQ-031 raw 16'hFD80 -> sign_o 1, int_bcd 12'h040, frac_bcd 16'h0000, crit/upper/lower 1/1/1; raw 16'h0FFF -> 255.9375 (12'h255, 16'h9375).
REQ-032 raw_valid with 16'h07D0, then raw_valid with 16'h0194 at E5 -> single result 125.0000 (12'h125, 16'h0000), overrun 1 until next capture, busy high through E24.
REQ-033 Start a conversion, assert rst=0 at E10 for 2 cycles -> all outputs 0 at once, no valid_o; a new raw_valid after release converts normally.
REQ-034 Back-to-back raw_valid at E25 -> accepted; the second result has correct latency and no stale digits.
